// File: rtl/quadrature_encoder_gen.sv
// Encoder emulator: turns signed step commands into paced Gray-code A/B edges and
// produces timed active-low button presses, tracking the emitted position.
module quadrature_encoder_gen #(
  parameter int STEP_CYCLES      = 1000000,
  parameter int BTN_PRESS_CYCLES = 1000000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic signed [15:0] cmd_steps,
  input  logic               abort,
  input  logic               btn_req,
  output logic               enc_a,
  output logic               enc_b,
  output logic               enc_btn_n,
  output logic               busy,
  output logic               btn_busy,
  output logic               done,
  output logic signed [15:0] position
);

  localparam int SCW = (STEP_CYCLES > 2) ? $clog2(STEP_CYCLES) : 1;
  localparam int BCW = (BTN_PRESS_CYCLES > 2) ? $clog2(BTN_PRESS_CYCLES) : 1;
  localparam logic [SCW-1:0] STEP_LAST = SCW'(STEP_CYCLES - 1);
  localparam logic [BCW-1:0] BTN_LAST  = BCW'(BTN_PRESS_CYCLES - 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  localparam logic [1:0] B_IDLE  = 2'd0;
  localparam logic [1:0] B_PRESS = 2'd1;
  localparam logic [1:0] B_GUARD = 2'd2;

  function automatic logic [1:0] phase_to_ab(input logic [1:0] ph);
    case (ph)
      2'd0:    return 2'b00;
      2'd1:    return 2'b01;
      2'd2:    return 2'b11;
      default: return 2'b10;
    endcase
  endfunction

  // 17 bits so that -32768 maps to a magnitude of 32768
  function automatic logic [16:0] step_magnitude(input logic signed [15:0] s);
    logic signed [16:0] ext;
    ext = {s[15], s};
    return ext[16] ? $unsigned(-ext) : $unsigned(ext);
  endfunction

  logic [0:0]         state;
  logic [1:0]         phase;
  logic [1:0]         phase_nxt;
  logic signed [15:0] position_nxt;
  logic [16:0]        remaining;
  logic               dir_ccw;
  logic [SCW-1:0]     dwell;

  logic [1:0]         bstate;
  logic [BCW-1:0]     bcnt;

  assign phase_nxt    = dir_ccw ? phase - 2'd1 : phase + 2'd1;
  assign position_nxt = dir_ccw ? position - 16'sd1 : position + 16'sd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      phase     <= 2'd0;
      position  <= 16'sd0;
      remaining <= 17'd0;
      dir_ccw   <= 1'b0;
      dwell     <= '0;
      done      <= 1'b0;
      busy      <= 1'b0;
      cmd_ready <= 1'b1;
      enc_a     <= 1'b0;
      enc_b     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            if (cmd_steps == 16'sd0) begin
              done <= 1'b1;
            end else begin
              state     <= S_RUN;
              busy      <= 1'b1;
              cmd_ready <= 1'b0;
              remaining <= step_magnitude(cmd_steps);
              dir_ccw   <= cmd_steps[15];
              dwell     <= '0;
            end
          end
        end
        default: begin
          // Abort takes priority over a step due on the same cycle
          if (abort || remaining == 17'd0) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            cmd_ready <= 1'b1;
            done      <= 1'b1;
          end else if (dwell == STEP_LAST) begin
            dwell          <= '0;
            remaining      <= remaining - 17'd1;
            phase          <= phase_nxt;
            position       <= position_nxt;
            {enc_a, enc_b} <= phase_to_ab(phase_nxt);
          end else begin
            dwell <= dwell + 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bstate    <= B_IDLE;
      bcnt      <= '0;
      enc_btn_n <= 1'b1;
      btn_busy  <= 1'b0;
    end else begin
      case (bstate)
        B_IDLE: begin
          if (btn_req) begin
            bstate    <= B_PRESS;
            bcnt      <= '0;
            enc_btn_n <= 1'b0;
            btn_busy  <= 1'b1;
          end
        end
        B_PRESS: begin
          if (bcnt == BTN_LAST) begin
            bstate    <= B_GUARD;
            bcnt      <= '0;
            enc_btn_n <= 1'b1;
          end else begin
            bcnt <= bcnt + 1'b1;
          end
        end
        B_GUARD: begin
          if (bcnt == BTN_LAST) begin
            bstate   <= B_IDLE;
            bcnt     <= '0;
            btn_busy <= 1'b0;
          end else begin
            bcnt <= bcnt + 1'b1;
          end
        end
        default: begin
          bstate    <= B_IDLE;
          bcnt      <= '0;
          enc_btn_n <= 1'b1;
          btn_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_quadrature_encoder_gen.sv
// Bench for quadrature_encoder_gen: time-based reference model, behavioural loopback
// decoder, and a second fast-paced instance for the full-range wrap case.
module tb_quadrature_encoder_gen;

  localparam int STEP = 4;
  localparam int BTN  = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst = 1'b1;
  logic               cmd_valid = 1'b0;
  logic signed [15:0] cmd_steps = 16'sd0;
  logic               abort = 1'b0;
  logic               btn_req = 1'b0;
  logic               cmd_ready, enc_a, enc_b, enc_btn_n, busy, btn_busy, done;
  logic signed [15:0] position;

  quadrature_encoder_gen #(.STEP_CYCLES(STEP), .BTN_PRESS_CYCLES(BTN)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_steps(cmd_steps), .abort(abort), .btn_req(btn_req),
    .enc_a(enc_a), .enc_b(enc_b), .enc_btn_n(enc_btn_n), .busy(busy),
    .btn_busy(btn_busy), .done(done), .position(position)
  );

  logic               w_valid = 1'b0;
  logic signed [15:0] w_steps = 16'sd0;
  logic               w_abort = 1'b0;
  logic               w_btn = 1'b0;
  logic               w_ready, w_a, w_b, w_btn_n, w_busy, w_bbusy, w_done;
  logic signed [15:0] w_pos;

  quadrature_encoder_gen #(.STEP_CYCLES(2), .BTN_PRESS_CYCLES(2)) u_wrap (
    .clk(clk), .rst(rst), .cmd_valid(w_valid), .cmd_ready(w_ready),
    .cmd_steps(w_steps), .abort(w_abort), .btn_req(w_btn),
    .enc_a(w_a), .enc_b(w_b), .enc_btn_n(w_btn_n), .busy(w_busy),
    .btn_busy(w_bbusy), .done(w_done), .position(w_pos)
  );

  logic [1:0] gray_ab [4] = '{2'b00, 2'b01, 2'b11, 2'b10};

  int passed = 0;
  int total  = 0;

  // Reference model state, expressed in absolute cycle times
  int         cyc = 0;
  logic       m_run = 1'b0, m_done = 1'b0, m_bact = 1'b0;
  int         m_t0 = 0, m_n = 0, m_bt0 = 0;
  logic [15:0] m_pos = 16'd0, m_dir = 16'd1;

  // Behavioural loopback decoder with a 2-cycle debounce
  logic [1:0]  dec_samp = 2'b00, dec_acc = 2'b00, dec_cnt = 2'd0;
  logic [15:0] dec_pos = 16'd0;

  function automatic logic [1:0] ab_idx(input logic [1:0] ab);
    case (ab)
      2'b00:   return 2'd0;
      2'b01:   return 2'd1;
      2'b11:   return 2'd2;
      default: return 2'd3;
    endcase
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      dec_samp <= 2'b00; dec_acc <= 2'b00; dec_cnt <= 2'd0; dec_pos <= 16'd0;
    end else if ({enc_a, enc_b} != dec_samp) begin
      dec_samp <= {enc_a, enc_b};
      dec_cnt  <= 2'd0;
    end else if (dec_cnt < 2'd1) begin
      dec_cnt <= dec_cnt + 2'd1;
    end else if (dec_acc != dec_samp) begin
      dec_acc <= dec_samp;
      if (2'(ab_idx(dec_samp) - ab_idx(dec_acc)) == 2'd1) dec_pos <= dec_pos + 16'd1;
      else dec_pos <= dec_pos - 16'd1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Advance one clock, update the model with the inputs that edge sampled, compare all outputs
  task automatic cycle();
    logic v, a, b, r;
    logic signed [15:0] s;
    v = cmd_valid; a = abort; b = btn_req; r = rst; s = cmd_steps;
    @(posedge clk); #1;
    cyc++;
    m_done = 1'b0;
    if (r) begin
      m_run = 1'b0; m_pos = 16'd0; m_bact = 1'b0;
    end else begin
      if (m_run) begin
        if (a || cyc == m_t0 + m_n * STEP + 1) begin
          m_run = 1'b0; m_done = 1'b1;
        end else if ((cyc - m_t0) % STEP == 0) begin
          m_pos = m_pos + m_dir;
        end
      end else if (v) begin
        if (s == 16'sd0) m_done = 1'b1;
        else begin
          m_run = 1'b1; m_t0 = cyc;
          m_n   = (s < 0) ? -int'(s) : int'(s);
          m_dir = (s < 0) ? 16'hffff : 16'h0001;
        end
      end
      if (m_bact) begin
        if (cyc - m_bt0 == 2 * BTN) m_bact = 1'b0;
      end else if (b) begin
        m_bact = 1'b1; m_bt0 = cyc;
      end
    end
    check("busy", 32'(busy), 32'(m_run));
    check("cmd_ready", 32'(cmd_ready), 32'(!m_run));
    check("done", 32'(done), 32'(m_done));
    check("position", 32'($unsigned(position)), 32'(m_pos));
    check("ab", 32'({enc_a, enc_b}), 32'(gray_ab[m_pos[1:0]]));
    check("btn_busy", 32'(btn_busy), 32'(m_bact));
    check("enc_btn_n", 32'(enc_btn_n), 32'(!(m_bact && (cyc - m_bt0) < BTN)));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic issue(input logic signed [15:0] s);
    cmd_valid = 1'b1; cmd_steps = s;
    cycle();
    cmd_valid = 1'b0;
  endtask

  initial begin
    int n, mag, ab_at, cnt;
    logic do_abort;

    run(2);
    rst = 1'b0;
    run(2);

    // +3 from reset: 01, 11, 10 at accept+4/8/12, done one cycle later
    issue(16'sd3);
    run(14);
    check("pos_after_p3", 32'($unsigned(position)), 32'd3);
    check("ab_after_p3", 32'({enc_a, enc_b}), 32'(2'b10));

    // -2 back to 1, then a zero-step command
    issue(-16'sd2);
    run(10);
    check("pos_after_m2", 32'($unsigned(position)), 32'd1);
    issue(16'sd0);
    check("zero_cmd_done", 32'(done), 32'd1);
    run(2);

    // +10 aborted on the cycle of the second edge
    issue(16'sd10);
    run(7);
    abort = 1'b1;
    cycle();
    abort = 1'b0;
    check("abort_pos", 32'($unsigned(position)), 32'd2);
    run(3);

    // abort in IDLE does not block an accept
    abort = 1'b1; cmd_valid = 1'b1; cmd_steps = 16'sd1;
    cycle();
    abort = 1'b0; cmd_valid = 1'b0;
    run(7);

    // button press concurrent with a step command, second request in guard dropped
    btn_req = 1'b1;
    issue(16'sd5);
    btn_req = 1'b0;
    run(10);
    btn_req = 1'b1;
    cycle();
    btn_req = 1'b0;
    run(30);

    // reset mid-RUN and mid-PRESS
    btn_req = 1'b1;
    issue(-16'sd6);
    btn_req = 1'b0;
    run(5);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check("rst_pos", 32'($unsigned(position)), 32'd0);
    check("rst_btn_n", 32'(enc_btn_n), 32'd1);
    run(3);

    // randomized commands with loopback tracking
    for (int it = 0; it < 14; it++) begin
      n   = int'($urandom_range(40)) - 20;
      mag = (n < 0) ? -n : n;
      do_abort = ($urandom_range(3) == 0);
      ab_at = int'($urandom_range(STEP * mag + 1, 1));
      btn_req = ($urandom_range(2) == 0);
      issue(16'(n));
      btn_req = 1'b0;
      for (int k = 1; k <= STEP * mag + 2 && m_run; k++) begin
        abort = do_abort && (k == ab_at);
        cycle();
        abort = 1'b0;
      end
      check("cmd_finished", 32'(busy), 32'd0);
      run(6);
      check("loopback", 32'(dec_pos), 32'($unsigned(position)));
    end
    run(2 * BTN);

    // full-range command and wrap on the fast instance
    w_valid = 1'b1; w_steps = -16'sd32768;
    cycle();
    w_valid = 1'b0;
    cnt = 0;
    while (!w_done && cnt < 70000) begin cycle(); cnt++; end
    check("wrap_long_len", 32'(cnt), 32'd65537);
    check("wrap_long_pos", 32'($unsigned(w_pos)), 32'h8000);
    check("wrap_long_ab", 32'({w_a, w_b}), 32'(2'b00));
    w_valid = 1'b1; w_steps = -16'sd1;
    cycle();
    w_valid = 1'b0;
    cnt = 0;
    while (!w_done && cnt < 10) begin cycle(); cnt++; end
    check("wrap_down_pos", 32'($unsigned(w_pos)), 32'h7fff);
    check("wrap_down_ab", 32'({w_a, w_b}), 32'(2'b10));
    w_valid = 1'b1; w_steps = 16'sd1;
    cycle();
    w_valid = 1'b0;
    cnt = 0;
    while (!w_done && cnt < 10) begin cycle(); cnt++; end
    check("wrap_up_pos", 32'($unsigned(w_pos)), 32'h8000);
    check("wrap_up_ab", 32'({w_a, w_b}), 32'(2'b00));
    check("wrap_ready", 32'(w_ready), 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
